// File: rtl/col_pkg.sv
// Shared types and widths for the column-decoder sequencer and its arbiter.
package col_pkg;

  localparam int COL_ADDR_W = 3;
  localparam int COL_DATA_W = 8;
  localparam int PH_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DRIVE = 2'd2,
    REL   = 2'd3
  } col_state_t;

  typedef enum logic {
    OP_CAM = 1'b0,
    OP_MAC = 1'b1
  } col_op_t;

endpackage

// File: rtl/col_rr_arb.sv
// Two-way round-robin arbiter, purely combinational.
// req[0]/req[1] are the two requesters; last = 1 means requester 1 was served
// most recently, so requester 0 wins a tie. en gates all grants off.
module col_rr_arb (
  input  logic       en,
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant the lone requester, or on a tie the one not served last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/col_ctrl.sv
// Column-decoder sequencer: arbitrates CAM-write and MAC requests and runs
// each granted operation through precharge -> drive -> release.
// Optional feature macro: COL_CTRL_STATS_EN adds saturating completion
// counters wr_count / mac_count.
//
// state | meaning
// IDLE  | bit lines free, decoder outputs 0, ready may be granted
// PRE   | bit-line precharge (pre_en), PRE_CYC cycles
// DRIVE | bit-line drive with word line on (wl_en), DRV_CYC cycles
// REL   | release, single cycle, done/done_mac pulse
module col_ctrl
  import col_pkg::*;
#(
  parameter int PRE_CYC = 2,
  parameter int DRV_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [COL_ADDR_W-1:0] wr_addr,
  output logic                  wr_ready,
  input  logic                  mac_valid,
  input  logic [COL_DATA_W-1:0] mac_data,
  output logic                  mac_ready,
  output logic                  dec_mac_en,
  output logic [COL_ADDR_W-1:0] dec_addr,
  output logic [COL_DATA_W-1:0] dec_data,
  output logic                  pre_en,
  output logic                  wl_en,
  output logic                  busy,
  output logic                  done,
  output logic                  done_mac
`ifdef COL_CTRL_STATS_EN
  ,
  output logic [15:0]           wr_count,
  output logic [15:0]           mac_count
`endif
);

  if (PRE_CYC < 1 || PRE_CYC > 15) begin : g_pre_chk
    $error("col_ctrl: PRE_CYC must be in 1..15");
  end
  if (DRV_CYC < 1 || DRV_CYC > 15) begin : g_drv_chk
    $error("col_ctrl: DRV_CYC must be in 1..15");
  end

  localparam logic [PH_CNT_W-1:0] PRE_LEN = PH_CNT_W'(PRE_CYC);
  localparam logic [PH_CNT_W-1:0] DRV_LEN = PH_CNT_W'(DRV_CYC);
  localparam logic [PH_CNT_W-1:0] CNT_ONE = PH_CNT_W'(1);

  col_state_t          state;
  logic [PH_CNT_W-1:0] cnt;
  col_op_t             last_grant;
  logic [1:0]          gnt;

  col_rr_arb u_arb (
    .en   (state == IDLE),
    .req  ({mac_valid, wr_valid}),
    .last (last_grant == OP_MAC),
    .gnt  (gnt)
  );

  assign wr_ready  = gnt[0];
  assign mac_ready = gnt[1];

  // Phase sequencer; decoder outputs double as the captured payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= OP_MAC;
      dec_mac_en <= 1'b0;
      dec_addr   <= '0;
      dec_data   <= '0;
      pre_en     <= 1'b0;
      wl_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_mac   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt[0]) begin
            state      <= PRE;
            cnt        <= PRE_LEN;
            last_grant <= OP_CAM;
            dec_mac_en <= 1'b0;
            dec_addr   <= wr_addr;
            dec_data   <= '0;
            pre_en     <= 1'b1;
            busy       <= 1'b1;
          end else if (gnt[1]) begin
            state      <= PRE;
            cnt        <= PRE_LEN;
            last_grant <= OP_MAC;
            dec_mac_en <= 1'b1;
            dec_addr   <= '0;
            dec_data   <= mac_data;
            pre_en     <= 1'b1;
            busy       <= 1'b1;
          end
        end
        PRE: begin
          if (cnt == CNT_ONE) begin
            state  <= DRIVE;
            cnt    <= DRV_LEN;
            pre_en <= 1'b0;
            wl_en  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DRIVE: begin
          if (cnt == CNT_ONE) begin
            state    <= REL;
            cnt      <= '0;
            wl_en    <= 1'b0;
            done     <= 1'b1;
            done_mac <= dec_mac_en;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        REL: begin
          state      <= IDLE;
          done       <= 1'b0;
          done_mac   <= 1'b0;
          busy       <= 1'b0;
          dec_mac_en <= 1'b0;
          dec_addr   <= '0;
          dec_data   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COL_CTRL_STATS_EN
  // Saturating completion counters, one per operation type.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count  <= '0;
      mac_count <= '0;
    end else if (done) begin
      if (!done_mac && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      if (done_mac && mac_count != 16'hFFFF)
        mac_count <= mac_count + 16'd1;
    end
  end
`endif

endmodule
